// File: rtl/msdf_otf_converter.sv
// -----------------------------------------------------------------------------
// msdf_otf_converter
//
// Purpose:
//   Converts the most-significant-digit-first radix-2 signed-digit product
//   stream of the MSDF serial-parallel multiplier into an (N+1)-bit
//   two's-complement word. On-the-fly conversion keeps two candidate words:
//     Q  : the value of the digits received so far
//     QM : that value minus one LSB at the current digit position
//   Each incoming digit selects one of them and appends a bit, so no
//   carry-propagate addition is needed. The full result is ready one cycle
//   after the last digit.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active high (wins over start)
//   start         one-cycle pulse, clears Q/QM/count and arms a conversion
//   zj[1:0]       signed digit (R2_POS_ONE / R2_ZERO / R2_NEG_ONE)
//   zj_valid      zj is valid this cycle (multiplier's ready_Zj)
//   result[N:0]   sum(z_j * 2^-j) * 2^N, held until the next completion
//   result_valid  one-cycle pulse when result has been updated
//   busy          high while digits are being accumulated
//   digit_err     sticky: an unused zj code was accepted
// -----------------------------------------------------------------------------

`ifndef R2_POS_ONE
`define R2_POS_ONE 2'b01
`endif
`ifndef R2_ZERO
`define R2_ZERO 2'b00
`endif
`ifndef R2_NEG_ONE
`define R2_NEG_ONE 2'b11
`endif

module msdf_otf_converter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   zj,
  input  logic         zj_valid,
  output logic [N:0]   result,
  output logic         result_valid,
  output logic         busy,
  output logic         digit_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  // Only the low N bits of Q and QM are stored: the MSB of each would be
  // shifted out by the next digit, and the final digit's full (N+1)-bit
  // word is taken straight from q_next_s into result.
  logic [N-1:0]    q_r;
  logic [N-1:0]    qm_r;
  logic [N:0]      result_r;
  logic            result_valid_r;
  logic            busy_r;
  logic            digit_err_r;

  logic [N:0]      q_next_s;
  logic [N:0]      qm_next_s;
  logic            bad_code_s;
  logic            accept_s;
  logic            last_digit_s;

  // Flags a digit code that is none of the three legal encodings.
  function automatic logic is_unused_code(input logic [1:0] code);
    logic unused;
    case (code)
      `R2_POS_ONE: unused = 1'b0;
      `R2_ZERO:    unused = 1'b0;
      `R2_NEG_ONE: unused = 1'b0;
      default:     unused = 1'b1;
    endcase
    return unused;
  endfunction

  // On-the-fly selection: next Q/QM words for the digit on zj.
  always_comb begin
    q_next_s   = {q_r,  1'b0};
    qm_next_s  = {qm_r, 1'b1};
    bad_code_s = is_unused_code(zj);
    case (zj)
      `R2_POS_ONE: begin
        q_next_s  = {q_r, 1'b1};
        qm_next_s = {q_r, 1'b0};
      end
      `R2_ZERO: begin
        q_next_s  = {q_r,  1'b0};
        qm_next_s = {qm_r, 1'b1};
      end
      `R2_NEG_ONE: begin
        q_next_s  = {qm_r, 1'b1};
        qm_next_s = {qm_r, 1'b0};
      end
      default: begin
        // Unused code is absorbed as a zero digit; digit_err records it.
        q_next_s  = {q_r,  1'b0};
        qm_next_s = {qm_r, 1'b1};
      end
    endcase
  end

  // Digit acceptance: only in ACC, and a coincident start discards the digit.
  always_comb begin
    if ((state_r == ST_ACC) && zj_valid && !start) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (count_r == CNT_LAST) begin
      last_digit_s = 1'b1;
    end else begin
      last_digit_s = 1'b0;
    end
  end

  // Control FSM, Q/QM shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      count_r        <= CNT_ZERO;
      q_r            <= {N{1'b0}};
      qm_r           <= {N{1'b1}};
      result_r       <= {(N+1){1'b0}};
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      digit_err_r    <= 1'b0;
    end else if (start) begin
      // Start from any state; a DONE-cycle pulse has already been presented.
      state_r        <= ST_ACC;
      count_r        <= CNT_ZERO;
      q_r            <= {N{1'b0}};
      qm_r           <= {N{1'b1}};
      result_valid_r <= 1'b0;
      busy_r         <= 1'b1;
      digit_err_r    <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_ACC: begin
          if (accept_s) begin
            q_r     <= q_next_s[N-1:0];
            qm_r    <= qm_next_s[N-1:0];
            count_r <= count_r + CNT_ONE;
            if (bad_code_s) begin
              digit_err_r <= 1'b1;
            end
            if (last_digit_s) begin
              // Result captured at the accepting edge so it is valid
              // throughout the DONE cycle alongside result_valid.
              state_r        <= ST_DONE;
              count_r        <= CNT_ZERO;
              result_r       <= q_next_s;
              result_valid_r <= 1'b1;
              busy_r         <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign digit_err    = digit_err_r;

endmodule

// File: tb/tb_msdf_otf_converter.sv
`ifndef R2_POS_ONE
`define R2_POS_ONE 2'b01
`endif
`ifndef R2_ZERO
`define R2_ZERO 2'b00
`endif
`ifndef R2_NEG_ONE
`define R2_NEG_ONE 2'b11
`endif

module tb_msdf_otf_converter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   zj;
  logic         zj_valid;
  logic [N:0]   result;
  logic         result_valid;
  logic         busy;
  logic         digit_err;

  int compared   = 0;
  int mismatched = 0;
  int rv_cnt     = 0;
  logic [1:0] unused_code;

  always #5 clk = ~clk;

  msdf_otf_converter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .zj           (zj),
    .zj_valid     (zj_valid),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .digit_err    (digit_err)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (result_valid === 1'b1) rv_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = sum z_j * 2^(N-j); unused codes count as zero.
  function automatic logic [N:0] model_value(input logic [1:0] codes [N]);
    int acc;
    logic [31:0] tmp;
    acc = 0;
    for (int j = 1; j <= N; j++) begin
      if (codes[j-1] == `R2_POS_ONE)      acc = acc + (1 << (N - j));
      else if (codes[j-1] == `R2_NEG_ONE) acc = acc - (1 << (N - j));
    end
    tmp = acc;
    return tmp[N:0];
  endfunction

  function automatic logic model_err(input logic [1:0] codes [N]);
    logic e;
    e = 1'b0;
    for (int j = 0; j < N; j++)
      if (codes[j] != `R2_POS_ONE && codes[j] != `R2_ZERO && codes[j] != `R2_NEG_ONE) e = 1'b1;
    return e;
  endfunction

  // One full conversion: start, digits with bubbles before digit i where
  // bub_mask[i] is set, then completion and post-completion checks.
  task automatic run_stream(input logic [1:0] codes [N], input logic [N-1:0] bub_mask,
                            input logic coincide, input string tag);
    int rv0;
    logic [N:0] exp_v;
    logic exp_e;
    exp_v = model_value(codes);
    exp_e = model_err(codes);
    rv0 = rv_cnt;
    start = 1'b1; zj_valid = coincide; zj = `R2_POS_ONE;
    cycle();
    start = 1'b0; zj_valid = 1'b0;
    check({tag, ".busy_after_start"}, busy, 32'd1);
    for (int i = 0; i < N; i++) begin
      if (bub_mask[i]) begin
        zj_valid = 1'b0;
        zj = 2'($urandom);
        cycle();
        check({tag, ".busy_bubble"}, busy, 32'd1);
      end
      zj = codes[i]; zj_valid = 1'b1;
      cycle();
      zj_valid = 1'b0;
      if (i < N - 1) begin
        check({tag, ".busy_mid"}, busy, 32'd1);
        check({tag, ".rv_early"}, result_valid, 32'd0);
      end
    end
    check({tag, ".rv_done"}, result_valid, 32'd1);
    check({tag, ".result"}, result, exp_v);
    check({tag, ".digit_err"}, digit_err, exp_e);
    check({tag, ".busy_done"}, busy, 32'd0);
    check({tag, ".rv_count"}, rv_cnt - rv0, 32'd1);
    cycle();
    check({tag, ".rv_drop"}, result_valid, 32'd0);
    check({tag, ".result_hold"}, result, exp_v);
  endtask

  initial begin
    logic [1:0] codes [N];
    logic [N-1:0] mask;
    int rv0;
    int cnt;
    int r;

    unused_code = 2'b00;
    for (int c = 3; c >= 0; c--)
      if (2'(c) != `R2_POS_ONE && 2'(c) != `R2_ZERO && 2'(c) != `R2_NEG_ONE) unused_code = 2'(c);

    rst = 1'b1; start = 1'b0; zj_valid = 1'b0; zj = `R2_ZERO;
    cycle(); cycle();
    check("reset.result", result, 32'd0);
    check("reset.rv", result_valid, 32'd0);
    check("reset.busy", busy, 32'd0);
    check("reset.err", digit_err, 32'd0);
    rst = 1'b0;
    zj_valid = 1'b1; zj = `R2_POS_ONE;
    cycle(); cycle();
    zj_valid = 1'b0;
    check("idle.ignore_busy", busy, 32'd0);
    check("idle.ignore_rv", rv_cnt, 32'd0);

    // Reference product 183/256
    codes = '{`R2_POS_ONE, `R2_POS_ONE, `R2_ZERO, `R2_NEG_ONE,
              `R2_POS_ONE, `R2_ZERO, `R2_NEG_ONE, `R2_POS_ONE};
    run_stream(codes, '0, 1'b0, "ref");
    check("ref.literal", result, 32'b010110111);

    // Extremes
    for (int i = 0; i < N; i++) codes[i] = `R2_POS_ONE;
    run_stream(codes, '0, 1'b0, "allpos");
    check("allpos.literal", result, 32'b011111111);
    for (int i = 0; i < N; i++) codes[i] = `R2_NEG_ONE;
    run_stream(codes, '0, 1'b0, "allneg");
    check("allneg.literal", result, 32'b100000001);
    for (int i = 0; i < N; i++) codes[i] = `R2_ZERO;
    codes[N-1] = `R2_POS_ONE;
    run_stream(codes, '0, 1'b0, "lsb");
    check("lsb.literal", result, 32'b000000001);

    // Bubbles and cancellation, then trailing digits in IDLE
    for (int i = 0; i < N; i++) codes[i] = `R2_ZERO;
    codes[0] = `R2_POS_ONE; codes[1] = `R2_NEG_ONE;
    mask = '0; cnt = 0;
    while (cnt < 3) begin
      r = $urandom_range(1, N - 1);
      if (!mask[r]) begin mask[r] = 1'b1; cnt++; end
    end
    run_stream(codes, mask, 1'b0, "bubble");
    check("bubble.literal", result, 32'b001000000);
    rv0 = rv_cnt;
    for (int i = 0; i < 5; i++) begin
      zj = `R2_POS_ONE; zj_valid = 1'b1;
      cycle();
      check("trail.busy", busy, 32'd0);
    end
    zj_valid = 1'b0;
    check("trail.no_rv", rv_cnt - rv0, 32'd0);
    check("trail.hold", result, 32'b001000000);

    // Restart mid-conversion
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      zj = `R2_NEG_ONE; zj_valid = 1'b1; cycle();
    end
    zj_valid = 1'b0;
    for (int i = 0; i < N; i++) codes[i] = `R2_POS_ONE;
    run_stream(codes, '0, 1'b0, "restart");

    // Start during the DONE cycle: pulse still seen, new conversion armed
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < N; i++) begin
      zj = `R2_NEG_ONE; zj_valid = 1'b1; cycle();
    end
    zj_valid = 1'b0;
    check("done_start.rv", result_valid, 32'd1);
    start = 1'b1; cycle(); start = 1'b0;
    check("done_start.busy", busy, 32'd1);
    check("done_start.rv_drop", result_valid, 32'd0);
    check("done_start.hold", result, 32'b100000001);

    // Reset mid-conversion, with start asserted alongside
    zj = unused_code; zj_valid = 1'b1; cycle();
    zj = `R2_POS_ONE; cycle();
    zj_valid = 1'b0;
    check("rstmid.err_set", digit_err, 32'd1);
    rv0 = rv_cnt;
    rst = 1'b1; start = 1'b1; zj_valid = 1'b1;
    cycle();
    rst = 1'b0; start = 1'b0;
    check("rstmid.result", result, 32'd0);
    check("rstmid.rv", result_valid, 32'd0);
    check("rstmid.busy", busy, 32'd0);
    check("rstmid.err", digit_err, 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    zj_valid = 1'b0;
    check("rstmid.no_rv", rv_cnt - rv0, 32'd0);
    check("rstmid.busy_idle", busy, 32'd0);

    // Unused code at digit 3
    for (int i = 0; i < N; i++) codes[i] = `R2_ZERO;
    codes[2] = unused_code;
    run_stream(codes, '0, 1'b0, "unused");
    check("unused.err_literal", digit_err, 32'd1);
    start = 1'b1; cycle(); start = 1'b0;
    check("unused.err_cleared", digit_err, 32'd0);

    // Start coincident with a valid digit: that digit is dropped
    for (int i = 0; i < N; i++) codes[i] = `R2_ZERO;
    run_stream(codes, '0, 1'b1, "coincide");

    // Randomized streams against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 15);
        if (r < 6)       codes[i] = `R2_POS_ONE;
        else if (r < 11) codes[i] = `R2_NEG_ONE;
        else if (r < 15) codes[i] = `R2_ZERO;
        else             codes[i] = unused_code;
      end
      mask = N'($urandom) & N'($urandom);
      run_stream(codes, mask, 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
